cascade_counter: RTL
====================

// Module: cascade_counter
// PURPOSE
//  Parametrised chain of NUM_STAGES modulo counters with per-stage programmable terminal values, up/down mode,
//  synchronous load and one-cycle carry pulses. Stages cascade by synchronous carry (stopwatch/clock style).
//  Includes a one-hot ring scanner that time-multiplexes stage values onto one output bus for display or readout.
// PARAMETERS
//  NUM_STAGES  3   number of cascaded stages; legal range >= 2
//  WIDTH       5   bits per stage counter
//  SCAN_DIV    4   clk cycles per scan-ring step; legal range >= 1
//  ADDR_W      $clog2(NUM_STAGES)  scan index width; derived, not overridable
// PORTS
//  clk         in   1                     clock, rising edge
//  rst         in   1                     synchronous, active-high reset
//  en          in   1                     count enable for stage 0
//  mode        in   1                     0 = up, 1 = down; sampled every cycle
//  load        in   1                     synchronous load of all stages
//  load_val    in   NUM_STAGES*WIDTH      load data; stage i = [i*WIDTH +: WIDTH]
//  limit       in   NUM_STAGES*WIDTH      terminal value per stage; same packing
//  count       out  NUM_STAGES*WIDTH      registered stage values; same packing
//  cout        out  NUM_STAGES            registered per-stage wrap pulse
//  scan_onehot out  NUM_STAGES            one-hot ring, bit i selects stage i
//  scan_addr   out  ADDR_W                binary index of the set scan_onehot bit
//  scan_value  out  WIDTH                 count of the selected stage; combinational from registers
// BEHAVIOUR
//  Reset values: count = 0, cout = 0, scan_onehot = 1 (stage 0), scan_addr = 0, scan prescaler = 0.
//  Priority per edge: rst > load > counting.
//  - load = 1: count <= load_val; cout <= 0; en is ignored this cycle; the scan ring is unaffected.
//  Tick: tick[0] = en. tick[i] = tick[i-1] AND stage i-1 wraps this cycle. All stages update on the same edge.
//  Up (mode = 0), stage ticked:
//  - cnt >= limit: cnt <= 0 and the stage wraps. cnt > limit can occur after limit is lowered.
//  - otherwise: cnt <= cnt + 1.
//  Down (mode = 1), stage ticked:
//  - cnt == 0: cnt <= limit and the stage wraps.
//  - cnt > limit: cnt <= limit, no wrap.
//  - otherwise: cnt <= cnt - 1.
//  Stage not ticked: holds its value.
//  cout[i] <= wrap[i]. A single-cycle pulse registered with the wrapped value. It is cleared on any cycle without a wrap.
//  limit = 0: stage wraps on every tick. Up and down give the same result.
//  Arithmetic is modulo 2^WIDTH. No wider intermediate is needed, because limit < 2^WIDTH.
//  Scan ring:
//  - free-running, independent of en, load and mode.
//  - the prescaler counts 0..SCAN_DIV-1. On the terminal value it resets to 0 and rotates scan_onehot left by one; the MSB wraps to the LSB.
//  - scan_addr is registered together with scan_onehot. scan_addr == index of the set bit, always.
//  - SCAN_DIV = 1: the ring rotates on every clk cycle.
//  Reset asserted mid-count or mid-load: all state returns to reset values on that edge.
//  No in-flight carry survives a reset.
// STRUCTURE
//  Package cascade_counter_pkg holds:
//  - MODE_UP = 1'b0, MODE_DOWN = 1'b1.
//  - a function that returns the next value and the wrap flag, given (cnt, limit, mode).
//  Sub-module cascade_stage (WIDTH) handles one stage.
//  - inputs: clk, rst, load, load_val, tick, mode, limit.
//  - outputs: cnt, wrap (combinational), cout (registered).
//  - the top generates NUM_STAGES of these and chains wrap into tick.
//  The scan ring and prescaler live in the top level.
// TESTING (NUM_STAGES = 3, WIDTH = 5, limits: stage0 = 9, stage1 = 5, stage2 = 23, SCAN_DIV = 4)
//  1. rst high 2 cycles with en = 1 -> count = 0, cout = 000, scan_onehot = 001, scan_addr = 0.
//  2. Up, en = 1 for 10 cycles from 0 -> stage0 runs 1..9 then 0, stage1 = 1; cout[0] = 1 exactly one cycle, cout[2:1] = 0.
//  3. load {23,5,9}, then up with en = 1 for 1 cycle -> count all 0, cout = 111 for one cycle, then 000.
//  4. Down from all 0, en = 1 for 1 cycle -> stages {23,5,9}, cout = 111; en = 0 next cycle -> values hold, cout = 000.
//  5. Scan check, en = 0 -> scan_onehot 001 -> 010 -> 100 -> 001 every 4 cycles; scan_addr 0,1,2,0; scan_value = selected stage.
//  6. Corner cases:
//   a. load = 1 and en = 1 together -> load_val taken, no count.
//   b. stage0 = 8, limit0 set to 3, up tick -> stage0 = 0, cout[0] = 1, stage1 increments.
//   c. rst = 1 with load = 1 -> all zero.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared types and the per-stage next-value rule
// for the cascaded modulo counter.
package cascade_counter_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Stage widths up to MAX_W-1 bits are supported.
  localparam int MAX_W = 32;

  typedef struct packed {
    logic             wrap;
    logic [MAX_W-1:0] nxt;
  } step_t;

  function automatic step_t next_step(
    input logic [MAX_W-1:0] cnt,
    input logic [MAX_W-1:0] limit,
    input logic             mode
  );
    step_t s;
    s.wrap = 1'b0;
    s.nxt  = cnt;
    if (mode == MODE_UP) begin
      if (cnt >= limit) begin
        s.nxt  = '0;
        s.wrap = 1'b1;
      end else begin
        s.nxt = cnt + 32'd1;
      end
    end else begin
      if (cnt == '0) begin
        s.nxt  = limit;
        s.wrap = 1'b1;
      end else if (cnt > limit) begin
        s.nxt = limit;
      end else begin
        s.nxt = cnt - 32'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/cascade_stage.sv
// One modulo counter stage: programmable terminal,
// up/down, synchronous load and registered carry.
module cascade_stage
  import cascade_counter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             cout
);

  step_t s;
  logic  unused_hi;

  always_comb begin
    s = next_step(MAX_W'(cnt), MAX_W'(limit), mode);
  end

  // Terminal condition, independent of tick so the
  // carry chain in the parent stays loop-free.
  assign wrap      = s.wrap;
  assign unused_hi = |s.nxt[MAX_W-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      cout <= 1'b0;
    end else begin
      if (tick)
        cnt <= s.nxt[WIDTH-1:0];
      cout <= tick & s.wrap;
    end
  end

endmodule

// File: rtl/cascade_counter.sv
// Chain of modulo counters cascaded by carry, plus a
// one-hot scan ring multiplexing stages onto one bus.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter  int NUM_STAGES = 3,
  parameter  int WIDTH      = 5,
  parameter  int SCAN_DIV   = 4,
  localparam int ADDR_W     = $clog2(NUM_STAGES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        mode,
  input  logic                        load,
  input  logic [NUM_STAGES*WIDTH-1:0] load_val,
  input  logic [NUM_STAGES*WIDTH-1:0] limit,
  output logic [NUM_STAGES*WIDTH-1:0] count,
  output logic [NUM_STAGES-1:0]       cout,
  output logic [NUM_STAGES-1:0]       scan_onehot,
  output logic [ADDR_W-1:0]           scan_addr,
  output logic [WIDTH-1:0]            scan_value
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NUM_STAGES-1:0] tick;
  logic [NUM_STAGES-1:0] wrap;
  logic [PW-1:0]         pre;
  logic                  unused_wrap;

  assign unused_wrap = wrap[NUM_STAGES-1];
  assign tick[0]     = en;

  for (genvar i = 1; i < NUM_STAGES; i++) begin : g_tick
    assign tick[i] = en & (&wrap[i-1:0]);
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    cascade_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .tick     (tick[i]),
      .mode     (mode),
      .limit    (limit[i*WIDTH +: WIDTH]),
      .cnt      (count[i*WIDTH +: WIDTH]),
      .wrap     (wrap[i]),
      .cout     (cout[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      scan_onehot <= NUM_STAGES'(1);
      scan_addr   <= '0;
    end else if (pre == PW'(SCAN_DIV - 1)) begin
      pre         <= '0;
      scan_onehot <= {scan_onehot[NUM_STAGES-2:0],
                      scan_onehot[NUM_STAGES-1]};
      scan_addr   <= (scan_addr == ADDR_W'(NUM_STAGES - 1))
                     ? '0 : scan_addr + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign scan_value = count[int'(scan_addr)*WIDTH +: WIDTH];

endmodule
